// File: rtl/mips32_mem_dump.sv
// Post-halt memory readout: walks a data-memory window on the rising edge of halted and streams
// each word out on a valid/ready port. Define MEM_DUMP_CHECKSUM_EN to append a checksum beat.
module mips32_mem_dump #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              halted,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W:0]   dump_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              out_is_csum,
    output logic              busy,
    output logic              done
);

`ifdef MEM_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StRd, StWt, StOut, StCsum, StDone} state_e;
    logic [DATA_W-1:0] acc;
    logic              is_csum_q;
    assign out_is_csum = is_csum_q;
`else
    typedef enum logic [2:0] {StIdle, StRd, StWt, StOut, StDone} state_e;
    assign out_is_csum = 1'b0;
`endif

    state_e            state;
    logic              halted_d;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   rem_next;
    logic [ADDR_W-1:0] addr_next;

    assign rem_next  = remaining - 1'b1;
    assign addr_next = addr + 1'b1;

    always_ff @(posedge clk1) begin
        if (reset) begin
            state       <= StIdle;
            halted_d    <= 1'b0;
            addr        <= '0;
            remaining   <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_addr    <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            acc         <= '0;
            is_csum_q   <= 1'b0;
`endif
        end else begin
            halted_d <= halted;
            case (state)
                StIdle: begin
                    if (halted && !halted_d) begin
                        addr      <= dump_base;
                        remaining <= dump_len;
`ifdef MEM_DUMP_CHECKSUM_EN
                        acc       <= '0;
`endif
                        if (dump_len == '0) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                            // Empty window still yields a single zero checksum beat
                            state     <= StCsum;
                            busy      <= 1'b1;
                            out_valid <= 1'b1;
                            out_data  <= '0;
                            out_addr  <= '0;
                            out_last  <= 1'b1;
                            is_csum_q <= 1'b1;
`else
                            state <= StDone;
                            done  <= 1'b1;
`endif
                        end else begin
                            state       <= StRd;
                            busy        <= 1'b1;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= dump_base;
                        end
                    end
                end
                StRd: begin
                    mem_rd_en <= 1'b0;
                    state     <= StWt;
                end
                StWt: begin
                    out_data  <= mem_rd_data;
                    out_addr  <= addr;
                    out_valid <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
`else
                    out_last  <= (remaining == 1);
`endif
                    state     <= StOut;
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        remaining <= rem_next;
                        addr      <= addr_next;
`ifdef MEM_DUMP_CHECKSUM_EN
                        acc       <= acc + out_data;
`endif
                        if (rem_next != '0) begin
                            state       <= StRd;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= addr_next;
                        end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
                            state     <= StCsum;
                            out_valid <= 1'b1;
                            out_data  <= acc + out_data;
                            out_addr  <= '0;
                            out_last  <= 1'b1;
                            is_csum_q <= 1'b1;
`else
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef MEM_DUMP_CHECKSUM_EN
                StCsum: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        is_csum_q <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= StDone;
                    end
                end
`endif
                StDone: begin
                    // Re-arming requires halted to drop before the next rising edge
                    if (!halted) begin
                        done  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_mem_dump.sv
// Randomized bench for mips32_mem_dump: expected beat list is derived from the memory image,
// window and checksum rule, and compared against every accepted output beat.
module tb_mips32_mem_dump;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic              clk1 = 1'b0;
    logic              reset;
    logic              halted;
    logic [ADDR_W-1:0] dump_base;
    logic [ADDR_W:0]   dump_len;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              out_is_csum;
    logic              busy;
    logic              done;

    mips32_mem_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk1        (clk1),
        .reset       (reset),
        .halted      (halted),
        .dump_base   (dump_base),
        .dump_len    (dump_len),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .out_last    (out_last),
        .out_is_csum (out_is_csum),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk1 = ~clk1;

    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk1) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
        logic              csum;
    } beat_t;

    beat_t exp_q[$];
    int    vectors = 0;
    int    errors  = 0;
    int    hs_count = 0;
    int    last_hs_cyc = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference: window words in order, wrapping modulo depth, plus optional running-sum beat
    task automatic build_exp(input int base, input int len);
        beat_t             e;
        logic [DATA_W-1:0] sum = '0;
        for (int i = 0; i < len; i++) begin
            e.addr = ADDR_W'((base + i) % DEPTH);
            e.data = mem[e.addr];
            e.last = (i == len - 1) && !CSUM;
            e.csum = 1'b0;
            sum    = sum + e.data;
            exp_q.push_back(e);
        end
        if (CSUM) begin
            e.addr = '0;
            e.data = sum;
            e.last = 1'b1;
            e.csum = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Output monitor: sampled on the falling edge, ahead of the edge that completes a handshake
    initial begin
        beat_t held;
        beat_t e;
        bit    holding = 1'b0;
        forever begin
            @(negedge clk1);
            if (reset) begin
                holding = 1'b0;
            end else begin
                if (holding) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_beat", {out_addr, out_data, out_last, out_is_csum}, held);
                end
                if (mem_rd_en) check("rd_while_valid", out_valid, 0);
                if (out_valid && out_ready) begin
                    check("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("beat_addr", out_addr, e.addr);
                        check("beat_data", out_data, e.data);
                        check("beat_last", out_last, e.last);
                        check("beat_csum", out_is_csum, e.csum);
                    end
                    hs_count++;
                    last_hs_cyc = cyc + 1;
                    holding = 1'b0;
                end else if (out_valid) begin
                    holding = 1'b1;
                    held = {out_addr, out_data, out_last, out_is_csum};
                end else begin
                    holding = 1'b0;
                end
            end
        end
    end

    task automatic wait_done(input int t0, input bit rnd, input bit drop,
                             output int first_rd, output int first_val, output bit seen);
        first_rd  = -1;
        first_val = -1;
        seen      = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(posedge clk1);
            #1;
            if (k == 0) begin
                dump_base = ADDR_W'($urandom);
                dump_len  = (ADDR_W + 1)'($urandom);
            end
            if (drop && k == 4) halted = 1'b0;
            if (mem_rd_en && first_rd < 0) begin
                first_rd = cyc;
                check("first_rd_addr", mem_rd_addr, exp_q.size() > 0 ? exp_q[0].addr : 0);
            end
            if (out_valid && first_val < 0) first_val = cyc;
            if (done) seen = 1'b1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic run_dump(input int base, input int len, input bit rnd, input bit drop);
        int t0, first_rd, first_val;
        bit seen;
        halted    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk1);
        #1;
        check("idle_done", done, 0);
        build_exp(base, len);
        dump_base = ADDR_W'(base);
        dump_len  = (ADDR_W + 1)'(len);
        halted    = 1'b1;
        t0        = cyc;
        wait_done(t0, rnd, drop, first_rd, first_val, seen);
        check("done_seen", seen, 1);
        check("beats_left", exp_q.size(), 0);
        check("busy_at_done", busy, 0);
        if (!rnd) begin
            if (len > 0) begin
                check("rd_latency", first_rd - t0, 1);
                check("valid_latency", first_val - t0, 3);
            end else begin
                check("zero_len_no_rd", first_rd < 0, 1);
            end
            if (CSUM || len > 0) check("done_latency", cyc - last_hs_cyc, 0);
            else check("done_latency", cyc - t0, 1);
        end
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, mem_rd_en, 0);
        check({tag, "_rd_addr"}, mem_rd_addr, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_addr"}, out_addr, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_is_csum"}, out_is_csum, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        int  h0, first_rd, first_val, t0;
        bit  found, seen;

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[198] = 32'd5040;
        mem[199] = 32'd0;
        mem[200] = 32'd7;

        reset     = 1'b1;
        halted    = 1'b0;
        out_ready = 1'b1;
        dump_base = '0;
        dump_len  = '0;
        repeat (3) @(posedge clk1);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        run_dump(198, 3, 1'b0, 1'b0);

        // halted held high after done must not start another dump
        for (int i = 0; i < 20; i++) begin
            @(posedge clk1);
            #1;
            check("rearm_rd_en", mem_rd_en, 0);
            check("rearm_done", done, 1);
        end
        run_dump(198, 3, 1'b0, 1'b0);

        run_dump(198, 3, 1'b1, 1'b0);
        run_dump(1023, 2, 1'b0, 1'b0);
        run_dump(198, 0, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            run_dump($urandom_range(0, DEPTH - 1), $urandom_range(0, 20), 1'b1, r == 2);
        end

        // Reset while beat 2 is waiting, with halted kept high so a fresh dump follows
        halted    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk1);
        #1;
        build_exp(198, 3);
        dump_base = ADDR_W'(198);
        dump_len  = (ADDR_W + 1)'(3);
        halted    = 1'b1;
        h0        = hs_count;
        found     = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk1);
            #1;
            if (hs_count == h0 + 1 && out_valid) found = 1'b1;
        end
        check("reach_beat2", found, 1);
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk1);
        #1;
        check_all_zero("midreset");
        reset = 1'b0;
        exp_q.delete();
        build_exp(198, 3);
        out_ready = 1'b1;
        t0 = cyc;
        wait_done(t0, 1'b0, 1'b0, first_rd, first_val, seen);
        check("restart_done", seen, 1);
        check("restart_beats_left", exp_q.size(), 0);
        check("restart_rd_latency", first_rd - t0, 1);
        exp_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mips32_mem_dump.md
# mips32_mem_dump

Post-halt memory readout engine for the pipelined MIPS32 core. When the core's `HALTED` flag rises, it walks a programmed window of data memory through a one-cycle-latency read port. Each word is presented on a valid/ready output stream with its address, so a bench or debug host can extract program results such as a factorial stored at address 198. It is the reading counterpart to program/data preload.

## Interface

Parameters:
- `ADDR_W`, default 10: memory address width; addresses wrap modulo 2^ADDR_W.
- `DATA_W`, default 32: memory word width.

Ports:
- `clk1`, in, 1: clock (core phase-1 clock); all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `halted`, in, 1: core `HALTED` flag.
- `dump_base`, in, ADDR_W: first address of the window; sampled at trigger.
- `dump_len`, in, ADDR_W+1: number of words; sampled at trigger; 0 is legal.
- `mem_rd_en`, out, 1: memory read strobe.
- `mem_rd_addr`, out, ADDR_W: read address.
- `mem_rd_data`, in, DATA_W: read data, valid exactly one cycle after `mem_rd_en`.
- `out_valid`, out, 1: output beat valid.
- `out_ready`, in, 1: consumer accept.
- `out_data`, out, DATA_W: word (or checksum, see Configuration).
- `out_addr`, out, ADDR_W: address of `out_data`.
- `out_last`, out, 1: final beat of the dump.
- `out_is_csum`, out, 1: beat carries checksum; tied 0 when the feature is off.
- `busy`, out, 1: dump in progress.
- `done`, out, 1: dump complete.

## Operation

- States: IDLE, RD, WT, OUT, CSUM, DONE.
- Trigger: in IDLE, when `halted`=1 and registered `halted_d`=0 (rising edge):
  - latch base into the address counter and len into the remaining counter;
  - go to RD, or to DONE if len=0.
- RD: drive `mem_rd_en`=1 and `mem_rd_addr`=current address for exactly one cycle, then go to WT.
- WT: capture `mem_rd_data` into `out_data`, current address into `out_addr`, and set `out_valid`. Set `out_last` when remaining=1 (and the checksum is disabled). Go to OUT.
- OUT: hold all output fields stable while `out_valid`=1 and `out_ready`=0. On handshake:
  - decrement remaining and increment the address (wrap from 2^ADDR_W−1 to 0);
  - go to RD if remaining is nonzero after the decrement;
  - otherwise go to CSUM (macro on) or DONE.
- DONE: `done`=1, `busy`=0. Stay until `halted`=0, then go to IDLE. A new dump needs a fresh rising edge of `halted`.
- `busy`=1 in RD, WT, OUT and CSUM.
- `halted` falling mid-dump is ignored; the dump runs to completion.
- `dump_base` and `dump_len` changes after the trigger are ignored.
- Reset at any time, including mid-handshake:
  - next cycle: state IDLE, counters 0, `halted_d`=0;
  - if `halted` is already 1 coming out of reset, the first cycle counts as a rising edge and triggers a dump.

## Timing

- Reset values: `mem_rd_en`, `mem_rd_addr`, `out_valid`, `out_data`, `out_addr`, `out_last`, `out_is_csum`, `busy` and `done` are all 0.
- Trigger to first `mem_rd_en`: 1 cycle.
- Trigger to first `out_valid`: 3 cycles.
- Steady state with `out_ready` held at 1: one beat per 3 cycles (RD, WT, OUT).
- Last handshake to `done`=1: 1 cycle (macro off). With the macro on, the checksum beat is presented 1 cycle after the last data handshake.
- `mem_rd_en` is never asserted while `out_valid`=1.
- `out_valid` never drops without a handshake.

## Configuration

- `MEM_DUMP_CHECKSUM_EN` defined:
  - a DATA_W-bit accumulator is cleared at trigger and adds each handshaken data word, modulo 2^DATA_W;
  - after the last data word, CSUM presents one extra beat with `out_data`=sum, `out_addr`=0, `out_is_csum`=1, `out_last`=1;
  - data beats never assert `out_last`;
  - for len=0, the dump is a single checksum beat with value 0.
- `MEM_DUMP_CHECKSUM_EN` undefined:
  - no accumulator and no CSUM state;
  - `out_is_csum` is constant 0;
  - `out_last` marks the last data word.

## Test plan

- Factorial result: mem[198]=5040, mem[199]=0, mem[200]=7; base=198, len=3; raise `halted`, `out_ready`=1.
  - Beats (198,5040), (199,0), (200,7), with `out_last` on the third.
  - `done`=1 one cycle after the last handshake.
  - Macro on: a fourth beat with value 5047, `out_is_csum`=1.
- Backpressure: same setup, `out_ready` toggling at random.
  - Each beat is held stable until accepted; no duplicated or dropped beats.
  - `mem_rd_en` is never high while `out_valid` is high.
- Wrap: base=1023, len=2 with ADDR_W=10.
  - Addresses 1023 then 0.
- Zero length: len=0.
  - No `mem_rd_en` and no beats; `done`=1 one cycle after trigger (macro off).
  - Macro on: a single beat with value 0, `out_last`=1.
- Re-arm: after `done`, hold `halted`=1 for 20 cycles.
  - No new dump.
  - Drop `halted`, raise it again: a second identical dump.
- Reset mid-dump: assert `reset` while `out_valid`=1 in beat 2.
  - All outputs 0 next cycle.
  - With `halted` held 1, a fresh dump restarts from the base address.
